digit_serial_driver: RTL

DIGIT_SERIAL_DRIVER -- requirements
Module: digit_serial_driver

---
 rtl/digit_serial_pkg.sv | 8 +
 rtl/digit_piso.sv | 22 ++
 rtl/digit_serial_driver.sv | 95 +++++++++
 3 files changed

// File: rtl/digit_serial_pkg.sv
// digit_serial_pkg: FSM states and default digit geometry shared by the
// digit-serial driver and the adder bench.
package digit_serial_pkg;
   typedef enum logic [1:0] {IDLE, SHIFT, DRAIN, DONE} state_e;
   localparam int DEF_W = 3;
   localparam int DEF_N = 2;
   localparam int DEF_LATENCY = 0;
endpackage

// File: rtl/digit_piso.sv
// digit_piso: N*W-bit parallel-in, digit-serial-out shift register.
// The low digit of the register drives dout directly, so the output is a flop.
module digit_piso #(
   parameter int W = 3,
   parameter int N = 2
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           load,
   input  logic           shift,
   input  logic [N*W-1:0] din,
   output logic [W-1:0]   dout
);
   logic [N*W-1:0] sr_q, sr_d;
   // Zeros shift in from the top, so dout returns to 0 after the last digit.
   always_comb sr_d = load ? din : shift ? sr_q >> W : sr_q;
   always_ff @(posedge clk) begin
      if (!reset) sr_q <= '0;
      else sr_q <= sr_d;
   end
   assign dout = sr_q[W-1:0];
endmodule

// File: rtl/digit_serial_driver.sv
// digit_serial_driver: serialises two parallel operands LSD-first into a
// digit-serial adder and reassembles the returned sum digits into out_sum.
module digit_serial_driver
   import digit_serial_pkg::*;
#(
   parameter int W = DEF_W,
   parameter int N = DEF_N,
   parameter int LATENCY = DEF_LATENCY
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [N*W-1:0] in_a,
   input  logic [N*W-1:0] in_b,
   output logic           first_digit,
   output logic           digit_valid,
   output logic [W-1:0]   a,
   output logic [W-1:0]   b,
   input  logic [W-1:0]   s,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [N*W-1:0] out_sum
);
   localparam int CW = $clog2(N + LATENCY + 1);
   localparam logic [CW-1:0] LAST_SHIFT = CW'(N - 1);
   localparam logic [CW-1:0] LAST_DRAIN = CW'(N + LATENCY - 1);

   state_e         state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           in_ready_q, in_ready_d;
   logic           first_digit_q, first_digit_d;
   logic           digit_valid_q, digit_valid_d;
   logic           out_valid_q, out_valid_d;
   logic [N*W-1:0] out_sum_q, out_sum_d;
   logic           accept, busy;

   assign accept = in_valid && in_ready_q;
   assign busy = state_q == SHIFT || state_q == DRAIN;

   digit_piso #(.W(W), .N(N)) u_piso_a (
      .clk(clk), .reset(reset), .load(accept), .shift(state_q == SHIFT), .din(in_a), .dout(a)
   );
   digit_piso #(.W(W), .N(N)) u_piso_b (
      .clk(clk), .reset(reset), .load(accept), .shift(state_q == SHIFT), .din(in_b), .dout(b)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q <= '0;
         in_ready_q <= 1'b0;
         first_digit_q <= 1'b0;
         digit_valid_q <= 1'b0;
         out_valid_q <= 1'b0;
         out_sum_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         in_ready_q <= in_ready_d;
         first_digit_q <= first_digit_d;
         digit_valid_q <= digit_valid_d;
         out_valid_q <= out_valid_d;
         out_sum_q <= out_sum_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = accept ? SHIFT : IDLE;
         SHIFT:   if (cnt_q == LAST_SHIFT) state_d = (LATENCY == 0) ? DONE : DRAIN;
         DRAIN:   if (cnt_q == LAST_DRAIN) state_d = DONE;
         DONE:    if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // in_ready is registered from IDLE, so it rises one edge after IDLE is entered.
   always_comb begin
      cnt_d = accept ? '0 : busy ? cnt_q + 1'b1 : cnt_q;
      in_ready_d = state_q == IDLE && !accept;
      first_digit_d = accept;
      digit_valid_d = state_d == SHIFT;
      out_valid_d = state_d == DONE;
      out_sum_d = out_sum_q;
      if (busy && int'(cnt_q) >= LATENCY) out_sum_d[(int'(cnt_q) - LATENCY) * W +: W] = s;
   end

   assign in_ready = in_ready_q;
   assign first_digit = first_digit_q;
   assign digit_valid = digit_valid_q;
   assign out_valid = out_valid_q;
   assign out_sum = out_sum_q;
endmodule
